bip_control: RTL
================

# bip_control

Sequencing and decode unit for the accumulator CPU: it fetches 16-bit instructions from program memory and drives the datapath select and strobe lines consumed by the `multiplexores` block and the ALU. These lines are `SelA`, `SelB`, `WrAcc` and `Op`, plus the data-memory and PC signals. Each instruction runs through a FETCH/DECODE/EXEC(/WB) state machine. The unit sits between program memory, data memory and the datapath.

## Interface
Parameters:
- NBITS_D, 16, instruction width
- NBITS_OP, 5, opcode field width (instruction [15:11])
- NBITS_PC, 11, program counter and operand/address width (instruction [10:0])

Ports:
- i_clock  in  1  system clock; all state updates on its rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_Enable  in  1  run enable, sampled only in FETCH
- i_Instr  in  NBITS_D  program-memory read data, valid the cycle after o_RdPM
- o_PC  out  NBITS_PC  program-memory address
- o_RdPM  out  1  program-memory read strobe
- o_Operand  out  NBITS_PC  IR[10:0], used as data-memory address and immediate source
- o_RdRam  out  1  data-memory read strobe
- o_WrRam  out  1  data-memory write strobe (store ACC)
- o_SelA  out  2  ACC source: 00 memory, 01 immediate, 10 ALU, 11 hold
- o_SelB  out  1  ALU B operand: 0 memory, 1 immediate
- o_WrAcc  out  1  accumulator write enable
- o_Op  out  1  ALU operation: 0 add, 1 subtract
- o_Halt  out  1  high while halted

## Operation
Opcodes:
- HLT 00000
- STO 00001
- LD 00010
- LDI 00011
- ADD 00100
- ADDI 00101
- SUB 00110
- SUBI 00111
- All other opcodes are executed as a NOP.

States:
- FETCH: o_RdPM=1. If i_Enable=1, go to DECODE; otherwise stay in FETCH.
- DECODE: latch IR <= i_Instr, then go to EXEC.
- EXEC, by opcode:
  - HLT: go to HALT; PC unchanged.
  - STO: o_WrRam=1; PC++; go to FETCH.
  - LDI: SelA=01, WrAcc=1; PC++; go to FETCH.
  - ADDI/SUBI: SelB=1, SelA=10, Op=0/1, WrAcc=1; PC++; go to FETCH.
  - LD/ADD/SUB: o_RdRam=1; go to WB.
  - NOP: PC++; go to FETCH.
- WB:
  - LD: SelA=00, WrAcc=1.
  - ADD/SUB: SelB=0, SelA=10, Op=0/1, WrAcc=1.
  - In both cases PC++ and go to FETCH.
- HALT: o_Halt=1. Stays in HALT until reset; i_Enable is ignored.

Output defaults (whenever not driven above): SelA=11, SelB=0, Op=0, all strobes 0.

Arithmetic and widths:
- PC increments modulo 2^NBITS_PC, so 2047 wraps to 0.
- The unit never does data arithmetic; o_Op only selects the ALU operation.

## Timing
- Reset (i_reset=0 at a rising edge): next cycle PC=0, state=FETCH, IR=0, o_SelA=11, o_SelB=0, o_Op=0, o_RdPM=1, all other strobes 0, o_Halt=0.
- Reset mid-instruction aborts it. No WrAcc or WrRam is issued after the reset edge.
- All outputs decode from the registered state, IR and PC only. There is no combinational path from i_Instr or i_Enable to any output.
- Latency per instruction:
  - STO, LDI, ADDI, SUBI, NOP: 3 cycles.
  - LD, ADD, SUB: 4 cycles.
  - HLT: 3 cycles to o_Halt=1.
- Data memory has a 1-cycle read latency: o_RdRam in EXEC, data consumed in WB.
- PC updates on the edge that leaves EXEC/WB. It is stable for the whole following FETCH.
- i_Enable=0 in FETCH stalls indefinitely. Deasserting i_Enable in any other state has no effect until the next FETCH.
- WrAcc and WrRam are exactly one cycle wide per instruction.

## Structure
- Package `bip_pkg` holds:
  - opcode constants
  - state encoding (FETCH, DECODE, EXEC, WB, HALT)
  - SelA codes (SEL_MEM, SEL_IMM, SEL_ALU, SEL_HOLD)
  - SelB codes and Op codes
- Sub-module `bip_decoder`: combinational opcode + state to control word (SelA, SelB, Op, WrAcc, RdRam, WrRam, next-state class).
- The top level keeps the FSM, PC and IR registers.

## Test plan
- Reset: hold i_reset=0 for 2 cycles, then release with i_Enable=1 -> o_PC=0, o_RdPM=1, o_SelA=11, all strobes 0, o_Halt=0.
- LDI then ADDI: program `LDI 5; ADDI 3` -> cycle 3 SelA=01, WrAcc=1; cycle 6 SelB=1, SelA=10, Op=0, WrAcc=1; o_PC = 1 then 2.
- Memory-operand path: `SUB 0x010` -> EXEC RdRam=1 with o_Operand=0x010; WB SelB=0, SelA=10, Op=1, WrAcc=1; 4 cycles total.
- STO and HLT: `STO 0x7FF; HLT` -> one-cycle WrRam with o_Operand=0x7FF; then o_Halt=1 with o_PC=1 held for 20 cycles despite i_Enable toggling.
- Stall and wrap: set PC to 2047 with NOP there and i_Enable=0 for 5 cycles -> stays in FETCH with o_PC=2047; after enabling, o_PC wraps to 0; opcode 11111 produces no strobes.
- Reset mid-WB: assert i_reset=0 during the WB of an LD -> no WrAcc pulse; next cycle matches the reset values.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared encodings for the accumulator CPU sequencer: opcodes, FSM states,
// datapath select codes and the decoded control word.
package bip_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_HLT  = 5'b00000;
   localparam logic [OP_W-1:0] OP_STO  = 5'b00001;
   localparam logic [OP_W-1:0] OP_LD   = 5'b00010;
   localparam logic [OP_W-1:0] OP_LDI  = 5'b00011;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00100;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00110;
   localparam logic [OP_W-1:0] OP_SUBI = 5'b00111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   localparam logic [1:0] SEL_MEM  = 2'b00;
   localparam logic [1:0] SEL_IMM  = 2'b01;
   localparam logic [1:0] SEL_ALU  = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

   localparam logic SELB_MEM = 1'b0;
   localparam logic SELB_IMM = 1'b1;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   typedef struct packed {
      logic [1:0] sel_a;
      logic       sel_b;
      logic       op;
      logic       wr_acc;
      logic       rd_ram;
      logic       wr_ram;
      logic       rd_pm;
      logic       halt;
      logic       pc_inc;
      state_t     nxt;
   } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Pure combinational decode of FSM state + opcode into the control word;
// zero latency, no flow control (the FSM in the top owns all sequencing).
module bip_decoder
   import bip_pkg::*;
(
   input  state_t          state,
   input  logic [OP_W-1:0] opcode,
   output ctrl_t           ctrl
);

   always_comb begin
      ctrl        = '0;
      ctrl.sel_a  = SEL_HOLD;
      ctrl.sel_b  = SELB_MEM;
      ctrl.op     = ALU_ADD;
      ctrl.nxt    = state;
      case (state)
         ST_FETCH: begin
            ctrl.rd_pm = 1'b1;
            ctrl.nxt   = ST_DECODE;
         end
         ST_DECODE: ctrl.nxt = ST_EXEC;
         ST_EXEC: begin
            case (opcode)
               OP_HLT: ctrl.nxt = ST_HALT;
               OP_STO: begin
                  ctrl.wr_ram = 1'b1;
                  ctrl.pc_inc = 1'b1;
                  ctrl.nxt    = ST_FETCH;
               end
               OP_LDI: begin
                  ctrl.sel_a  = SEL_IMM;
                  ctrl.wr_acc = 1'b1;
                  ctrl.pc_inc = 1'b1;
                  ctrl.nxt    = ST_FETCH;
               end
               OP_ADDI, OP_SUBI: begin
                  ctrl.sel_b  = SELB_IMM;
                  ctrl.sel_a  = SEL_ALU;
                  ctrl.op     = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
                  ctrl.wr_acc = 1'b1;
                  ctrl.pc_inc = 1'b1;
                  ctrl.nxt    = ST_FETCH;
               end
               // Memory operands: read issued now, consumed in WB next cycle.
               OP_LD, OP_ADD, OP_SUB: begin
                  ctrl.rd_ram = 1'b1;
                  ctrl.nxt    = ST_WB;
               end
               default: begin
                  ctrl.pc_inc = 1'b1;
                  ctrl.nxt    = ST_FETCH;
               end
            endcase
         end
         ST_WB: begin
            ctrl.wr_acc = 1'b1;
            ctrl.pc_inc = 1'b1;
            ctrl.nxt    = ST_FETCH;
            if (opcode == OP_LD) begin
               ctrl.sel_a = SEL_MEM;
            end else begin
               ctrl.sel_a = SEL_ALU;
               ctrl.sel_b = SELB_MEM;
               ctrl.op    = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            end
         end
         ST_HALT: begin
            ctrl.halt = 1'b1;
            ctrl.nxt  = ST_HALT;
         end
         default: ctrl.nxt = ST_FETCH;
      endcase
   end

endmodule

// File: rtl/bip_control.sv
// Accumulator CPU sequencer: FETCH/DECODE/EXEC(/WB) FSM with PC and IR; 3 cycles per
// instruction, 4 for memory operands. Stalls in FETCH while i_Enable=0; HALT is terminal.
module bip_control
   import bip_pkg::*;
#(
   parameter int NBITS_D  = 16,
   parameter int NBITS_OP = 5,
   parameter int NBITS_PC = 11
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_Enable,
   input  logic [NBITS_D-1:0]  i_Instr,
   output logic [NBITS_PC-1:0] o_PC,
   output logic                o_RdPM,
   output logic [NBITS_PC-1:0] o_Operand,
   output logic                o_RdRam,
   output logic                o_WrRam,
   output logic [1:0]          o_SelA,
   output logic                o_SelB,
   output logic                o_WrAcc,
   output logic                o_Op,
   output logic                o_Halt
);

   state_t              state;
   logic [NBITS_D-1:0]  ir;
   logic [NBITS_PC-1:0] pc;
   ctrl_t               ctrl;

   bip_decoder u_decoder (
      .state  (state),
      .opcode (ir[NBITS_D-1 -: NBITS_OP]),
      .ctrl   (ctrl)
   );

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state <= ST_FETCH;
         ir    <= '0;
         pc    <= '0;
      end else begin
         if (state == ST_DECODE)
            ir <= i_Instr;
         if (ctrl.pc_inc)
            pc <= pc + 1'b1;
         if (state != ST_FETCH || i_Enable)
            state <= ctrl.nxt;
      end
   end

   assign o_PC      = pc;
   assign o_RdPM    = ctrl.rd_pm;
   assign o_Operand = ir[NBITS_PC-1:0];
   assign o_RdRam   = ctrl.rd_ram;
   // A write landing on a reset edge would commit an aborted instruction.
   assign o_WrRam   = ctrl.wr_ram & i_reset;
   assign o_WrAcc   = ctrl.wr_acc & i_reset;
   assign o_SelA    = ctrl.sel_a;
   assign o_SelB    = ctrl.sel_b;
   assign o_Op      = ctrl.op;
   assign o_Halt    = ctrl.halt;

endmodule
